// File: rtl/program_memory_arbiter.sv
// Single-port program memory arbiter: loader writes have priority over instruction fetch reads.
// Optional macro PMEM_ARB_STARVE_GUARD_EN adds a starvation counter that forces a fetch grant.
module program_memory_arbiter #(
  parameter int PC_WIDTH     = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [PC_WIDTH-1:0]   fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  input  logic                  ld_req,
  input  logic [PC_WIDTH-1:0]   ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  output logic                  ld_gnt,
  output logic                  mem_w_en,
  output logic [PC_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [PC_WIDTH:0]     ld_count
);

  localparam logic [PC_WIDTH:0] CNT_ONE = {{PC_WIDTH{1'b0}}, 1'b1};
  localparam logic [PC_WIDTH:0] CNT_MAX = {(PC_WIDTH+1){1'b1}};

  // The starvation counter is 4 bits wide, so only limits 1..15 are meaningful.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("STARVE_LIMIT must lie in 1..15");
  end

  logic fetch_hs_s;
  logic ld_hs_s;
  logic starve_hit_s;
  logic fetch_pend_r;

`ifdef PMEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0] starve_r;

  assign starve_hit_s = (starve_r == STARVE_MAX);

  // Count consecutive cycles fetch is left waiting; saturate at the limit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_r <= 4'd0;
    end else if (fetch_req && !fetch_gnt) begin
      if (starve_r != STARVE_MAX) begin
        starve_r <= starve_r + 4'd1;
      end else begin
        starve_r <= starve_r;
      end
    end else begin
      starve_r <= 4'd0;
    end
  end
`else
  assign starve_hit_s = 1'b0;
`endif

  // Grant selection: loader wins ties unless fetch has waited long enough.
  always_comb begin
    fetch_gnt = 1'b0;
    ld_gnt    = 1'b0;
    if (!rst) begin
      fetch_gnt = 1'b0;
      ld_gnt    = 1'b0;
    end else if (fetch_req && ld_req) begin
      if (starve_hit_s) begin
        fetch_gnt = 1'b1;
      end else begin
        ld_gnt = 1'b1;
      end
    end else if (ld_req) begin
      ld_gnt = 1'b1;
    end else if (fetch_req) begin
      fetch_gnt = 1'b1;
    end else begin
      fetch_gnt = 1'b0;
      ld_gnt    = 1'b0;
    end
  end

  assign fetch_hs_s = fetch_req & fetch_gnt;
  assign ld_hs_s    = ld_req & ld_gnt;
  assign fetch_data = mem_rdata;

  // Memory command register plus the read pipeline that times fetch_valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_w_en     <= 1'b0;
      mem_addr     <= {PC_WIDTH{1'b0}};
      mem_wdata    <= {DATA_WIDTH{1'b0}};
      fetch_pend_r <= 1'b0;
      fetch_valid  <= 1'b0;
      ld_count     <= {(PC_WIDTH+1){1'b0}};
    end else begin
      mem_w_en     <= ld_hs_s;
      fetch_pend_r <= fetch_hs_s;
      fetch_valid  <= fetch_pend_r;
      if (ld_hs_s) begin
        mem_addr  <= ld_addr;
        mem_wdata <= ld_wdata;
        if (ld_count != CNT_MAX) begin
          ld_count <= ld_count + CNT_ONE;
        end else begin
          ld_count <= ld_count;
        end
      end else if (fetch_hs_s) begin
        mem_addr <= fetch_addr;
      end else begin
        mem_addr  <= mem_addr;
        mem_wdata <= mem_wdata;
      end
    end
  end

endmodule

// File: tb/tb_program_memory_arbiter.sv
// Scoreboard bench for program_memory_arbiter: queued requesters, a memory model and a
// reference model of grants, memory contents, write/fetch latencies and the loader count.
module tb_program_memory_arbiter;

  localparam int PW = 8;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam int CNT_SAT = (1 << (PW + 1)) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fetch_req = 1'b0;
  logic [PW-1:0] fetch_addr = '0;
  logic          fetch_gnt;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          ld_req = 1'b0;
  logic [PW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_wdata = '0;
  logic          ld_gnt;
  logic          mem_w_en;
  logic [PW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [PW:0]   ld_count;

  program_memory_arbiter #(.PC_WIDTH(PW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .ld_count(ld_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [PW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { logic [DW-1:0] d; int due; } fexp_t;
  typedef struct { logic [PW-1:0] a; logic [DW-1:0] d; int due; } wexp_t;

  logic [DW-1:0] phys_mem [0:255];
  logic [DW-1:0] ref_mem  [0:255];
  logic [PW-1:0] fq[$];
  wr_t           lq[$];
  fexp_t         fexp[$];
  wexp_t         wexp[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int starve = 0;
  int cnt = 0;
  int win = 100;
  int win_f = 0;
  bit f_hs = 1'b0;
  bit l_hs = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Program memory stand-in: one-cycle read latency, write on the same edge.
  always @(posedge clk) begin
    if (mem_w_en) phys_mem[mem_addr] <= mem_wdata;
    mem_rdata <= phys_mem[mem_addr];
  end

  // Monitor: compare outputs against the expectation queues, then advance the model.
  always @(negedge clk) begin
    fexp_t e;
    wexp_t w;
    bit ef;
    bit el;
    cyc++;
    if (wexp.size() > 0 && wexp[0].due == cyc) begin
      w = wexp.pop_front();
      chk("wr_strobe", mem_w_en, 1'b1);
      chk("wr_addr", mem_addr, w.a);
      chk("wr_data", mem_wdata, w.d);
    end else begin
      chk("wr_idle", mem_w_en, 1'b0);
    end
    if (fexp.size() > 0 && fexp[0].due == cyc) begin
      e = fexp.pop_front();
      chk("fetch_valid", fetch_valid, 1'b1);
      chk("fetch_data", fetch_data, e.d);
    end else begin
      chk("fetch_idle", fetch_valid, 1'b0);
    end
    chk("ld_count", ld_count, cnt);

    ef = 1'b0;
    el = 1'b0;
    if (rst) begin
      if (fetch_req && ld_req) begin
`ifdef PMEM_ARB_STARVE_GUARD_EN
        if (starve == SL) ef = 1'b1; else el = 1'b1;
`else
        el = 1'b1;
`endif
      end else if (ld_req) el = 1'b1;
      else if (fetch_req) ef = 1'b1;
    end
    chk("fetch_gnt", fetch_gnt, ef);
    chk("ld_gnt", ld_gnt, el);
    f_hs = ef;
    l_hs = el;
    if (win < 10) begin
      win++;
      if (fetch_req && fetch_gnt) win_f++;
    end

    if (!rst) begin
      fexp.delete();
      wexp.delete();
      starve = 0;
      cnt = 0;
    end else begin
      if (el) begin
        ref_mem[ld_addr] = ld_wdata;
        wexp.push_back('{ld_addr, ld_wdata, cyc + 1});
        if (cnt < CNT_SAT) cnt++;
      end
      if (ef) fexp.push_back('{ref_mem[fetch_addr], cyc + 2});
      if (fetch_req && !ef) starve = (starve < SL) ? starve + 1 : starve;
      else starve = 0;
    end
  end

  // Driver: each requester holds its request until the model reports a handshake.
  initial begin
    forever begin
      wr_t op;
      @(posedge clk);
      #1;
      if (fetch_req) begin
        if (f_hs) begin
          if (fq.size() > 0) fetch_addr = fq.pop_front();
          else fetch_req = 1'b0;
        end
      end else if (fq.size() > 0) begin
        fetch_addr = fq.pop_front();
        fetch_req = 1'b1;
      end
      if (ld_req) begin
        if (l_hs) begin
          if (lq.size() > 0) begin
            op = lq.pop_front();
            ld_addr = op.a;
            ld_wdata = op.d;
          end else ld_req = 1'b0;
        end
      end else if (lq.size() > 0) begin
        op = lq.pop_front();
        ld_addr = op.a;
        ld_wdata = op.d;
        ld_req = 1'b1;
      end
    end
  end

  task automatic wait_idle(int budget);
    int n = 0;
    while ((fq.size() > 0 || lq.size() > 0 || fetch_req || ld_req ||
            fexp.size() > 0 || wexp.size() > 0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL drain_timeout: still busy after %0d cycles, limit %0d", n, budget);
    end
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_wen"}, mem_w_en, 1'b0);
    chk({tag, "_addr"}, mem_addr, '0);
    chk({tag, "_wdata"}, mem_wdata, '0);
    chk({tag, "_fvalid"}, fetch_valid, 1'b0);
    chk({tag, "_count"}, ld_count, '0);
    chk({tag, "_gnts"}, {fetch_gnt, ld_gnt}, 2'b00);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin
      phys_mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0203);
      ref_mem[i]  = phys_mem[i];
    end
    phys_mem[4] = 32'hDEAD_BEEF;
    ref_mem[4]  = 32'hDEAD_BEEF;

    // Reset held three cycles with both requesters already waiting.
    fq.push_back(8'd20);
    lq.push_back('{8'd30, 32'h1234_5678});
    repeat (3) begin
      @(negedge clk);
      #1;
      chk_reset_outputs("reset");
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_idle(50);

    // Single fetch of a preloaded word.
    fq.push_back(8'd4);
    wait_idle(50);

    // Write then read-back of the same address on the next cycle.
    lq.push_back('{8'd12, 32'h1111_1111});
    fq.push_back(8'd12);
    wait_idle(50);

    // Both requesters saturated: count fetch grants in a 10-cycle window.
    @(posedge clk);
    #2;
    for (int i = 0; i < 12; i++) fq.push_back(8'($urandom_range(0, 63)));
    for (int i = 0; i < 10; i++) lq.push_back('{8'($urandom_range(0, 63)), $urandom});
    @(posedge clk);
    #2;
    win = 0;
    win_f = 0;
    wait_idle(100);
`ifdef PMEM_ARB_STARVE_GUARD_EN
    chk("starve_window_fetch_grants", win_f, 2);
`else
    chk("starve_window_fetch_grants", win_f, 0);
`endif

    // Back-to-back fetch stream.
    fq.push_back(8'd0);
    fq.push_back(8'd4);
    fq.push_back(8'd12);
    fq.push_back(8'd40);
    wait_idle(50);

    // Reset asserted the cycle after a fetch handshake drops the read.
    fq.push_back(8'd20);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!f_hs && n < 20);
    chk("midreset_handshake_seen", f_hs, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_idle(50);

    // Random mixed traffic over a small address range to exercise read-after-write.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      if (fq.size() < 2 && $urandom_range(0, 2) == 0) fq.push_back(8'($urandom_range(0, 15)));
      if (lq.size() < 2 && $urandom_range(0, 2) == 0)
        lq.push_back('{8'($urandom_range(0, 15)), $urandom});
    end
    wait_idle(200);

    // Loader count saturation.
    for (int i = 0; i < CNT_SAT + 10; i++) lq.push_back('{8'($urandom_range(0, 255)), $urandom});
    wait_idle(CNT_SAT + 100);
    @(negedge clk);
    #1;
    chk("ld_count_saturated", ld_count, 9'h1FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_memory_arbiter.md
# program_memory_arbiter

Arbitrates the single port of the CPU program memory between two requesters: the instruction-fetch unit (read-only) and the program loader (write-only). Sits between both requesters and `program_memory`, driving its `w_en`, address and write data and returning read data to fetch with a valid strobe. Pipelined: one memory transaction per cycle, loader-priority with a configurable starvation guard for fetch.

## Interface
Parameters:
- `PC_WIDTH`, 8, program memory address width
- `DATA_WIDTH`, 32, instruction word width
- `STARVE_LIMIT`, 4, consecutive denied fetch cycles before fetch is forced to win (legal range 1..15)

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `fetch_req`  in  1  fetch requests a read; holds `fetch_addr` stable until granted
- `fetch_addr`  in  PC_WIDTH  read address
- `fetch_gnt`  out  1  combinational; handshake completes at the edge where `fetch_req && fetch_gnt`
- `fetch_valid`  out  1  registered; `fetch_data` holds the requested word
- `fetch_data`  out  DATA_WIDTH  read data, passthrough of `mem_rdata`
- `ld_req`  in  1  loader requests a write; holds `ld_addr`/`ld_wdata` stable until granted
- `ld_addr`  in  PC_WIDTH  write address
- `ld_wdata`  in  DATA_WIDTH  write data
- `ld_gnt`  out  1  combinational; handshake at edge where `ld_req && ld_gnt`
- `mem_w_en`  out  1  registered write strobe to program memory
- `mem_addr`  out  PC_WIDTH  registered memory address
- `mem_wdata`  out  DATA_WIDTH  registered memory write data
- `mem_rdata`  in  DATA_WIDTH  memory read data, valid one cycle after `mem_addr` is presented
- `ld_count`  out  PC_WIDTH+1  number of completed loader writes since reset, saturating

## Operation
- Grant logic (combinational, at most one grant per cycle):
  - only one requester active -> it is granted
  - both active -> `ld_gnt`, unless starvation counter == `STARVE_LIMIT`, then `fetch_gnt`
  - neither active -> no grant
- Starvation counter (4 bits): +1 each cycle `fetch_req && !fetch_gnt`, saturating at `STARVE_LIMIT`; cleared on fetch handshake or when `fetch_req` low.
- On fetch handshake at edge E0: `mem_addr <= fetch_addr`, `mem_w_en <= 0`; pipeline bit set so `fetch_valid` = 1 for exactly one cycle after edge E1.
- On loader handshake at E0: `mem_addr <= ld_addr`, `mem_wdata <= ld_wdata`, `mem_w_en <= 1` for exactly one cycle; `ld_count` += 1 (saturates at 2^(PC_WIDTH+1)-1).
- No handshake: `mem_w_en <= 0`; `mem_addr`/`mem_wdata` hold.
- Back-to-back handshakes from the same or alternating requesters are legal every cycle.
- Write at E0 followed by fetch of the same address at E1 returns the new word (memory sees write at E1, read at E2).

## Timing
- Reset (`rst`=0 at an edge): `mem_w_en`=0, `mem_addr`=0, `mem_wdata`=0, `fetch_valid`=0, `ld_count`=0, starvation counter=0; grants forced 0 while `rst`=0.
- Reset mid-operation: in-flight fetch dropped, no `fetch_valid` produced; pending write not issued.
- Fetch latency: handshake edge E0 -> `fetch_valid` high in cycle after E1 (2 cycles).
- Write latency: handshake E0 -> `mem_w_en` high in cycle after E0.
- Worst-case fetch wait with loader saturating: `STARVE_LIMIT` cycles.

## Configuration
- `PMEM_ARB_STARVE_GUARD_EN` defined: starvation counter and forced fetch grant as above.
- Not defined: counter removed; strict loader priority, fetch waits indefinitely while `ld_req` high.

## Test plan
- Reset: hold `rst`=0 3 cycles with both reqs high -> grants 0, all outputs 0, `ld_count`=0.
- Single fetch, mem preloaded addr 4 = 0xDEADBEEF: `fetch_req`, addr 4 -> `fetch_gnt` same cycle, `fetch_valid` 2 cycles later with 0xDEADBEEF.
- Loader writes 0x11111111@12 then fetch of 12 next cycle -> one `mem_w_en` pulse, fetch returns 0x11111111, `ld_count`=1.
- Both reqs held high 10 cycles, `STARVE_LIMIT`=4 -> grant order L,L,L,L,F repeating; without macro -> all L.
- Fetch streaming addrs 0,4,12,40 back-to-back -> 4 consecutive `fetch_valid` pulses, data in order.
- `rst` asserted the cycle after a fetch handshake -> no `fetch_valid`, outputs return to reset values.
